// File: rtl/ramio_arbiter.sv
// Two-requester round-robin arbiter in front of a single ramio port.
// A grant latches the winner's request; the ramio side sees only latched fields, and only during ACCESS.
module ramio_arbiter #(
    parameter int AddressBitwidth = 32,
    parameter int DataBitwidth    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       r0_req,
    input  logic [2:0]                 r0_read_type,
    input  logic [1:0]                 r0_write_type,
    input  logic [AddressBitwidth-1:0] r0_address,
    input  logic [DataBitwidth-1:0]    r0_data_in,
    output logic [DataBitwidth-1:0]    r0_data_out,
    output logic                       r0_done,

    input  logic                       r1_req,
    input  logic [2:0]                 r1_read_type,
    input  logic [1:0]                 r1_write_type,
    input  logic [AddressBitwidth-1:0] r1_address,
    input  logic [DataBitwidth-1:0]    r1_data_in,
    output logic [DataBitwidth-1:0]    r1_data_out,
    output logic                       r1_done,

    output logic                       m_enable,
    output logic [2:0]                 m_read_type,
    output logic [1:0]                 m_write_type,
    output logic [AddressBitwidth-1:0] m_address,
    output logic [DataBitwidth-1:0]    m_data_in,
    input  logic [DataBitwidth-1:0]    m_data_out,
    input  logic                       m_data_out_ready,
    input  logic                       m_busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_e;

    state_e                     state_q, state_d;
    logic                       last_grant_q, last_grant_d;
    logic                       id_q, id_d;
    logic [2:0]                 read_type_q, read_type_d;
    logic [1:0]                 write_type_q, write_type_d;
    logic [AddressBitwidth-1:0] address_q, address_d;
    logic [DataBitwidth-1:0]    data_in_q, data_in_d;
    logic [DataBitwidth-1:0]    r0_data_out_q, r0_data_out_d;
    logic [DataBitwidth-1:0]    r1_data_out_q, r1_data_out_d;

    logic winner;
    logic access_complete;

    // With both requesting, the one not granted last wins; otherwise whoever is requesting.
    assign winner = (r0_req && r1_req) ? ~last_grant_q : ~r0_req;

    assign access_complete = (state_q == ACCESS) && !m_busy &&
                             ((read_type_q == 3'b000) || m_data_out_ready);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can leave one unassigned (no latches).
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        id_d          = id_q;
        read_type_d   = read_type_q;
        write_type_d  = write_type_q;
        address_d     = address_q;
        data_in_d     = data_in_q;
        r0_data_out_d = r0_data_out_q;
        r1_data_out_d = r1_data_out_q;

        case (state_q)
            IDLE: begin
                if (r0_req || r1_req) begin
                    id_d         = winner;
                    last_grant_d = winner;
                    read_type_d  = winner ? r1_read_type  : r0_read_type;
                    write_type_d = winner ? r1_write_type : r0_write_type;
                    address_d    = winner ? r1_address    : r0_address;
                    data_in_d    = winner ? r1_data_in    : r0_data_in;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (access_complete) begin
                    if (read_type_q != 3'b000) begin
                        if (id_q) r1_data_out_d = m_data_out;
                        else      r0_data_out_d = m_data_out;
                    end
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            id_q          <= 1'b0;
            read_type_q   <= '0;
            write_type_q  <= '0;
            address_q     <= '0;
            data_in_q     <= '0;
            r0_data_out_q <= '0;
            r1_data_out_q <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            id_q          <= id_d;
            read_type_q   <= read_type_d;
            write_type_q  <= write_type_d;
            address_q     <= address_d;
            data_in_q     <= data_in_d;
            r0_data_out_q <= r0_data_out_d;
            r1_data_out_q <= r1_data_out_d;
        end
    end

    // The ramio side is forced to zero outside ACCESS so I/O side effects fire only there.
    assign m_enable     = (state_q == ACCESS);
    assign m_read_type  = m_enable ? read_type_q  : '0;
    assign m_write_type = m_enable ? write_type_q : '0;
    assign m_address    = m_enable ? address_q    : '0;
    assign m_data_in    = m_enable ? data_in_q    : '0;

    assign r0_done     = (state_q == DONE) && !id_q;
    assign r1_done     = (state_q == DONE) &&  id_q;
    assign r0_data_out = r0_data_out_q;
    assign r1_data_out = r1_data_out_q;

endmodule
